// File: rtl/cell_proc_sequencer.sv
// cell_proc_sequencer: job-level controller for the CellProcessor datapath.
// Takes a job descriptor (opcode, user operand, cell count) and streams that
// many cell pairs into the processor, holding opcode/user stable for the job.
// Processor results are captured PROC_LATENCY cycles after each issue into a
// first-word-fall-through FIFO and presented as a valid/ready pixel stream.
// Issue is credit-limited so output backpressure never loses a pixel even
// though the processor itself cannot stall.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   job_valid/job_ready           job descriptor handshake (IDLE only)
//   job_opcode/job_user/job_count job descriptor fields
//   cell_valid/cell_ready         cell pair handshake, cell_a/cell_b data
//   proc_cellA/B, proc_userInputA, proc_opcode   drive the CellProcessor
//   proc_pixel                    processed pixel back from the CellProcessor
//   pix_valid/pix_ready           output pixel handshake, pix_data/pix_last
//   busy                          not idle
//   done                          one-cycle pulse when a job completes

package CellProcessingPkg;
  typedef logic [7:0] cellDepth;
  typedef logic [7:0] userInput_t;
  typedef logic [7:0] pixel_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_MAX} opcodes_t;
endpackage

module cell_proc_sequencer
  import CellProcessingPkg::*;
#(
  parameter int unsigned PROC_LATENCY = 2,
  parameter int unsigned OUT_DEPTH    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  opcodes_t         job_opcode,
  input  userInput_t       job_user,
  input  logic [CNT_W-1:0] job_count,
  input  logic             cell_valid,
  output logic             cell_ready,
  input  cellDepth         cell_a,
  input  cellDepth         cell_b,
  output cellDepth         proc_cellA,
  output cellDepth         proc_cellB,
  output userInput_t       proc_userInputA,
  output opcodes_t         proc_opcode,
  input  pixel_t           proc_pixel,
  output logic             pix_valid,
  input  logic             pix_ready,
  output pixel_t           pix_data,
  output logic             pix_last,
  output logic             busy,
  output logic             done
);

  if (PROC_LATENCY < 1 || OUT_DEPTH < PROC_LATENCY) begin : g_param_check
    $fatal(1, "cell_proc_sequencer: require PROC_LATENCY >= 1 and OUT_DEPTH >= PROC_LATENCY");
  end

  localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(OUT_DEPTH + PROC_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_rem_q, issue_rem_d;
  logic [CNT_W-1:0]  out_rem_q, out_rem_d;
  logic [PROC_LATENCY-1:0] vpipe_q, vpipe_d;
  cellDepth          proc_cella_q, proc_cella_d;
  cellDepth          proc_cellb_q, proc_cellb_d;
  userInput_t        proc_user_q, proc_user_d;
  opcodes_t          proc_opcode_q, proc_opcode_d;
  pixel_t            mem_q [OUT_DEPTH];
  pixel_t            mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              fifo_wr;
  logic              fifo_full;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every issued cell owns a FIFO slot from issue until it is popped, so the
  // FIFO can never overflow however long pix_ready stays low.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PROC_LATENCY; i++) begin
      inflight = inflight + OCC_W'(vpipe_q[i]);
    end
    occupancy = inflight + OCC_W'(fifo_cnt_q);
  end

  assign cell_ready = (state_q == S_RUN) && (issue_rem_q != '0) &&
                      (occupancy < OCC_W'(OUT_DEPTH));
  assign issue      = cell_valid && cell_ready;
  assign fifo_wr    = vpipe_q[PROC_LATENCY-1];
  assign fifo_full  = (fifo_cnt_q == FCNT_W'(OUT_DEPTH));
  assign pix_valid  = (fifo_cnt_q != '0);
  assign pop        = pix_valid && pix_ready;
  assign pix_data   = pix_valid ? mem_q[rd_ptr_q] : '0;
  assign pix_last   = pix_valid && (out_rem_q == CNT_W'(1));
  assign busy       = (state_q != S_IDLE);

  assign proc_cellA      = proc_cella_q;
  assign proc_cellB      = proc_cellb_q;
  assign proc_userInputA = proc_user_q;
  assign proc_opcode     = proc_opcode_q;

  // Control FSM and job counters
  always_comb begin
    state_d       = state_q;
    issue_rem_d   = issue_rem_q;
    out_rem_d     = out_rem_q;
    proc_cella_d  = proc_cella_q;
    proc_cellb_d  = proc_cellb_q;
    proc_user_d   = proc_user_q;
    proc_opcode_d = proc_opcode_q;
    job_ready     = 1'b0;
    done          = 1'b0;

    if (pop) begin
      out_rem_d = out_rem_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          proc_opcode_d = job_opcode;
          proc_user_d   = job_user;
          issue_rem_d   = job_count;
          out_rem_d     = job_count;
          state_d       = (job_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          proc_cella_d = cell_a;
          proc_cellb_d = cell_b;
          issue_rem_d  = issue_rem_q - 1'b1;
          if (issue_rem_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_rem_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid pipeline and output FIFO
  always_comb begin
    vpipe_d[0] = issue;
    for (int unsigned i = 1; i < PROC_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = proc_pixel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({fifo_wr, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      issue_rem_q   <= '0;
      out_rem_q     <= '0;
      vpipe_q       <= '0;
      proc_cella_q  <= '0;
      proc_cellb_q  <= '0;
      proc_user_q   <= '0;
      proc_opcode_q <= opcodes_t'('0);
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      issue_rem_q   <= issue_rem_d;
      out_rem_q     <= out_rem_d;
      vpipe_q       <= vpipe_d;
      proc_cella_q  <= proc_cella_d;
      proc_cellb_q  <= proc_cellb_d;
      proc_user_q   <= proc_user_d;
      proc_opcode_q <= proc_opcode_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full))
    else $error("cell_proc_sequencer: output fifo written while full");

endmodule

// File: tb/tb_cell_proc_sequencer.sv
// Testbench for cell_proc_sequencer: table of single-cell jobs with
// hand-computed pixels, plus directed multi-cycle sequences, with a
// behavioural CellProcessor and a cycle-level scoreboard.
module tb_cell_proc_sequencer;
  import CellProcessingPkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  opcodes_t      job_opcode;
  userInput_t    job_user;
  logic [CW-1:0] job_count;
  logic          cell_valid;
  logic          cell_ready;
  cellDepth      cell_a, cell_b;
  cellDepth      proc_cellA, proc_cellB;
  userInput_t    proc_userInputA;
  opcodes_t      proc_opcode;
  pixel_t        proc_pixel;
  logic          pix_valid;
  logic          pix_ready;
  pixel_t        pix_data;
  logic          pix_last;
  logic          busy;
  logic          done;

  cell_proc_sequencer #(.PROC_LATENCY(LAT), .OUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_opcode(job_opcode),
    .job_user(job_user), .job_count(job_count),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_a(cell_a), .cell_b(cell_b),
    .proc_cellA(proc_cellA), .proc_cellB(proc_cellB),
    .proc_userInputA(proc_userInputA), .proc_opcode(proc_opcode),
    .proc_pixel(proc_pixel),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic pixel_t proc_fn(opcodes_t op, userInput_t u, cellDepth a, cellDepth b);
    cellDepth m;
    case (op)
      OP_ADD:  return a + b + u;
      OP_SUB:  return a - b + u;
      OP_XOR:  return a ^ b ^ u;
      default: begin
        m = (a > b) ? a : b;
        return (m > u) ? m : u;
      end
    endcase
  endfunction

  // Behavioural CellProcessor: LAT-1 register stages after the combinational op.
  pixel_t pstage [LAT-1];
  always @(posedge clk) begin
    pstage[0] <= proc_fn(proc_opcode, proc_userInputA, proc_cellA, proc_cellB);
    for (int i = 1; i < LAT - 1; i++) pstage[i] <= pstage[i-1];
  end
  assign proc_pixel = pstage[LAT-2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output ready driver: 0 = always ready, 1 = never ready, 2 = random 50%
  int ready_mode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'b0;
        default: pix_ready = ($urandom_range(1) == 1);
      endcase
    end
  end

  // Scoreboard / reference model, sampled on the falling edge
  pixel_t     exp_q [$];
  cellDepth   model_a, model_b;
  opcodes_t   model_op;
  userInput_t model_user;
  int         model_out_rem;
  int pop_cnt = 0, last_cnt = 0, done_cnt = 0;
  int first_iss_cyc = -1, first_pix_cyc = -1;
  int last_done_cyc = -1, last_acc_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_a = '0; model_b = '0; model_op = OP_ADD; model_user = '0; model_out_rem = 0;
    end else begin
      chk("proc_cellA", 32'(proc_cellA), 32'(model_a));
      chk("proc_cellB", 32'(proc_cellB), 32'(model_b));
      chk("proc_opcode", 32'(proc_opcode), 32'(model_op));
      chk("proc_user", 32'(proc_userInputA), 32'(model_user));
      chk("pix_last", 32'(pix_last), 32'(pix_valid && model_out_rem == 1));
      if (pix_valid && first_pix_cyc < 0) first_pix_cyc = cyc;
      if (pix_valid && pix_ready) begin
        pop_cnt++;
        if (pix_last) last_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected: got pixel %0h expected none", pix_data);
        end else begin
          chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        end
        model_out_rem--;
      end
      if (cell_valid && cell_ready) begin
        exp_q.push_back(proc_fn(model_op, model_user, cell_a, cell_b));
        model_a = cell_a; model_b = cell_b;
        if (first_iss_cyc < 0) first_iss_cyc = cyc;
      end
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (job_valid && job_ready) begin
        model_op = job_opcode; model_user = job_user;
        model_out_rem = int'(job_count); last_acc_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    pop_cnt = 0; last_cnt = 0; done_cnt = 0; first_iss_cyc = -1; first_pix_cyc = -1;
  endtask

  task automatic start_job(input opcodes_t op, input userInput_t u, input int cnt);
    int n = 0;
    job_opcode = op; job_user = u; job_count = CW'(cnt); job_valid = 1'b1;
    while (!job_ready && n < 200) begin tick(); n++; end
    if (!job_ready) chk("job_accept_timeout", 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
  endtask

  // mode: 0 random data, 1 sequential A=k, B=10k, 2 fixed fa/fb
  task automatic feed(input int n, input int pct, input int mode, input cellDepth fa,
                      input cellDepth fb, input int budget, output int issued);
    int used = 0;
    issued = 0;
    while (issued < n && used < budget) begin
      cell_valid = (int'($urandom_range(99)) < pct);
      case (mode)
        0:       begin cell_a = 8'($urandom); cell_b = 8'($urandom); end
        1:       begin cell_a = 8'(issued + 1); cell_b = 8'(10 * (issued + 1)); end
        default: begin cell_a = fa; cell_b = fb; end
      endcase
      if (cell_valid && cell_ready) issued++;
      tick(); used++;
    end
    cell_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("job_ready_in_done", 32'(job_ready), 32'd0);
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    opcodes_t   op;
    userInput_t user;
    cellDepth   a;
    cellDepth   b;
    pixel_t     exp;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int iss, n, dc0;
    vecs[0] = '{OP_ADD, 8'd5,   8'd1,   8'd10,  8'd16};
    vecs[1] = '{OP_ADD, 8'd0,   8'd200, 8'd100, 8'd44};
    vecs[2] = '{OP_SUB, 8'd5,   8'd20,  8'd3,   8'd22};
    vecs[3] = '{OP_SUB, 8'd0,   8'd3,   8'd20,  8'd239};
    vecs[4] = '{OP_XOR, 8'hFF,  8'h0F,  8'hF0,  8'h00};
    vecs[5] = '{OP_XOR, 8'h01,  8'hAA,  8'h55,  8'hFE};
    vecs[6] = '{OP_MAX, 8'd7,   8'd9,   8'd3,   8'd9};
    vecs[7] = '{OP_MAX, 8'd200, 8'd9,   8'd3,   8'd200};

    rst = 1'b1; job_valid = 1'b0; job_opcode = OP_ADD; job_user = '0; job_count = '0;
    cell_valid = 1'b0; cell_a = '0; cell_b = '0; pix_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_cell_ready", 32'(cell_ready), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_last", 32'(pix_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_proc_cellA", 32'(proc_cellA), 32'd0);
    chk("rst_proc_cellB", 32'(proc_cellB), 32'd0);
    chk("rst_proc_user", 32'(proc_userInputA), 32'd0);
    chk("rst_proc_opcode", 32'(proc_opcode), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);

    // Table of single-cell jobs with hand-computed pixels
    ready_mode = 0;
    for (int i = 0; i < 8; i++) begin
      start_job(vecs[i].op, vecs[i].user, 1);
      feed(1, 100, 2, vecs[i].a, vecs[i].b, 20, iss);
      n = 0;
      while (!pix_valid && n < 20) begin tick(); n++; end
      chk("vec_pix_valid", 32'(pix_valid), 32'd1);
      chk("vec_pix_data", 32'(pix_data), 32'(vecs[i].exp));
      chk("vec_pix_last", 32'(pix_last), 32'd1);
      wait_done(20);
    end

    // Four-cell job, latency and last flag
    clear_stats();
    start_job(OP_SUB, 8'd5, 4);
    feed(4, 100, 1, '0, '0, 20, iss);
    chk("t1_issued", 32'(iss), 32'd4);
    wait_done(50);
    chk("t1_pixels", 32'(pop_cnt), 32'd4);
    chk("t1_last_cnt", 32'(last_cnt), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_latency", 32'(first_pix_cyc - first_iss_cyc), 32'(1 + LAT));
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length job
    clear_stats();
    start_job(OP_XOR, 8'd3, 0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cell_ready", 32'(cell_ready), 32'd0);
    chk("t2_pix_valid", 32'(pix_valid), 32'd0);
    chk("t2_job_ready", 32'(job_ready), 32'd0);
    tick();
    chk("t2_done_gone", 32'(done), 32'd0);
    chk("t2_idle", 32'(job_ready), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_pixels", 32'(pop_cnt), 32'd0);

    // Output stalled: only DEPTH cells may be issued
    clear_stats();
    ready_mode = 1;
    start_job(OP_ADD, 8'd9, 10);
    feed(10, 100, 0, '0, '0, 12, iss);
    chk("t3_credit_limit", 32'(iss), 32'(DEPTH));
    chk("t3_cell_ready_low", 32'(cell_ready), 32'd0);
    chk("t3_fifo_full_valid", 32'(pix_valid), 32'd1);
    ready_mode = 0;
    feed(6, 100, 0, '0, '0, 60, iss);
    chk("t3_rest_issued", 32'(iss), 32'd6);
    wait_done(60);
    chk("t3_pixels", 32'(pop_cnt), 32'd10);
    chk("t3_last_cnt", 32'(last_cnt), 32'd1);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random gaps on both sides
    clear_stats();
    ready_mode = 2;
    start_job(OP_MAX, 8'd77, 100);
    feed(100, 50, 0, '0, '0, 2000, iss);
    chk("t4_issued", 32'(iss), 32'd100);
    wait_done(500);
    chk("t4_pixels", 32'(pop_cnt), 32'd100);
    chk("t4_last_cnt", 32'(last_cnt), 32'd1);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a job
    clear_stats();
    ready_mode = 1;
    start_job(OP_XOR, 8'd33, 8);
    feed(3, 100, 0, '0, '0, 3, iss);
    chk("t5_issued", 32'(iss), 32'd3);
    chk("t5_busy", 32'(busy), 32'd1);
    dc0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_job_ready", 32'(job_ready), 32'd1);
    chk("t5_cell_ready", 32'(cell_ready), 32'd0);
    chk("t5_pix_valid", 32'(pix_valid), 32'd0);
    chk("t5_pix_last", 32'(pix_last), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_proc_cellA", 32'(proc_cellA), 32'd0);
    chk("t5_proc_opcode", 32'(proc_opcode), 32'd0);
    chk("t5_pix_data", 32'(pix_data), 32'd0);
    ready_mode = 0;
    repeat (5) tick();
    chk("t5_no_pix_after_rst", 32'(pix_valid), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'(dc0));
    clear_stats();
    start_job(OP_ADD, 8'd1, 2);
    feed(2, 100, 0, '0, '0, 20, iss);
    wait_done(50);
    chk("t5_new_pixels", 32'(pop_cnt), 32'd2);
    chk("t5_new_last", 32'(last_cnt), 32'd1);

    // Back-to-back jobs
    clear_stats();
    start_job(OP_ADD, 8'd4, 3);
    feed(3, 100, 1, '0, '0, 20, iss);
    start_job(OP_SUB, 8'd8, 2);
    chk("t6_accept_after_done", 32'(last_acc_cyc), 32'(last_done_cyc + 1));
    chk("t6_first_pixels", 32'(pop_cnt), 32'd3);
    feed(2, 100, 0, '0, '0, 20, iss);
    wait_done(50);
    chk("t6_pixels", 32'(pop_cnt), 32'd5);
    chk("t6_last_cnt", 32'(last_cnt), 32'd2);
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
